// File: rtl/mem_arb_pkg.sv
// Shared types and default geometry for the main-memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_LINE_WORDS  = 32'd4;
  localparam int unsigned DEF_MEM_LATENCY = 32'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_DR = 2'd2,
    BUSY_DW = 2'd3
  } arbState_t;

  // Side served most recently; the other side wins the next tie.
  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } lastGrant_t;

endpackage

// File: rtl/beat_sequencer.sv
// Word/latency counters for one line transfer: a beat is MEM_LATENCY cycles,
// a line is LINE_WORDS beats.
module beat_sequencer
  import mem_arb_pkg::*;
#(
  parameter int unsigned LINE_WORDS  = DEF_LINE_WORDS,
  parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY,
  parameter int unsigned WIDX_W      = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              enable,
  output logic              beatEnd,
  output logic              lineEnd,
  output logic [WIDX_W-1:0] wordIdx
);

  localparam int unsigned LAT_W = (MEM_LATENCY > 32'd1) ? $clog2(MEM_LATENCY) : 32'd1;

  logic [LAT_W-1:0]  latCnt_r;
  logic [WIDX_W-1:0] wordIdx_r;
  logic              beatEnd_s;
  logic              lineEnd_s;

  // Beat and line boundary decode.
  always_comb begin
    beatEnd_s = 1'b0;
    lineEnd_s = 1'b0;
    if (enable && (latCnt_r == LAT_W'(MEM_LATENCY - 32'd1))) begin
      beatEnd_s = 1'b1;
      lineEnd_s = (wordIdx_r == WIDX_W'(LINE_WORDS - 32'd1));
    end else begin
      beatEnd_s = 1'b0;
      lineEnd_s = 1'b0;
    end
  end

  // Counter update; the word index wraps to 0 naturally at line end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latCnt_r  <= '0;
      wordIdx_r <= '0;
    end else if (start) begin
      latCnt_r  <= '0;
      wordIdx_r <= '0;
    end else if (beatEnd_s) begin
      latCnt_r  <= '0;
      wordIdx_r <= wordIdx_r + WIDX_W'(1);
    end else if (enable) begin
      latCnt_r  <= latCnt_r + LAT_W'(1);
    end
  end

  assign beatEnd = beatEnd_s;
  assign lineEnd = lineEnd_s;
  assign wordIdx = wordIdx_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and line sequencer between the I-refill / D-miss paths
// and a single-ported fixed-latency main memory.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LINE_WORDS  = DEF_LINE_WORDS,
  parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY,
  parameter int unsigned WIDX_W      = $clog2(LINE_WORDS)
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_grant,
  output logic [31:0]       i_rdata,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [WIDX_W-1:0] d_widx,
  output logic              d_grant,
  output logic [31:0]       d_rdata,
  output logic              d_rvalid,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  arbState_t         state_r, nextState_s;
  lastGrant_t        lastGrant_r;
  logic [31:0]       lineAddr_r;
  logic [31:0]       iRdata_r, dRdata_r;
  logic              iRvalid_r, dRvalid_r, iDone_r, dDone_r;
  logic              reqI_s, reqD_s, grantI_s, grantD_s;
  logic              beatEnd_s, lineEnd_s;
  logic [WIDX_W-1:0] wordIdx_s;
  logic              iGrant_s, dGrant_s, memEn_s, memWe_s;
  logic [31:0]       memAddr_s, memWdata_s;
  logic [WIDX_W-1:0] dWidx_s;
  logic              unusedLowBits_s;

  beat_sequencer #(
    .LINE_WORDS (LINE_WORDS),
    .MEM_LATENCY(MEM_LATENCY),
    .WIDX_W     (WIDX_W)
  ) u_seq (
    .clk    (Clk),
    .reset  (reset),
    .start  (grantI_s | grantD_s),
    .enable (state_r != IDLE),
    .beatEnd(beatEnd_s),
    .lineEnd(lineEnd_s),
    .wordIdx(wordIdx_s)
  );

  // Arbitration and next state; a side whose done is showing is not re-granted.
  always_comb begin
    nextState_s = state_r;
    grantI_s    = 1'b0;
    grantD_s    = 1'b0;
    reqI_s      = i_req & ~iDone_r;
    reqD_s      = d_req & ~dDone_r;
    case (state_r)
      IDLE: begin
        if (reqI_s && reqD_s) begin
          if (lastGrant_r == LAST_I) begin
            grantD_s = 1'b1;
          end else begin
            grantI_s = 1'b1;
          end
        end else if (reqI_s) begin
          grantI_s = 1'b1;
        end else if (reqD_s) begin
          grantD_s = 1'b1;
        end else begin
          grantI_s = 1'b0;
        end
        if (grantD_s) begin
          nextState_s = d_we ? BUSY_DW : BUSY_DR;
        end else if (grantI_s) begin
          nextState_s = BUSY_I;
        end else begin
          nextState_s = IDLE;
        end
      end
      BUSY_I, BUSY_DR, BUSY_DW: begin
        if (lineEnd_s) begin
          nextState_s = IDLE;
        end else begin
          nextState_s = state_r;
        end
      end
      default: nextState_s = IDLE;
    endcase
  end

  // State, round-robin history and line address captured at grant.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      lastGrant_r <= LAST_I;
      lineAddr_r  <= 32'h0000_0000;
    end else begin
      state_r <= nextState_s;
      if (grantI_s) begin
        lineAddr_r  <= i_addr;
        lastGrant_r <= LAST_I;
      end else if (grantD_s) begin
        lineAddr_r  <= d_addr;
        lastGrant_r <= LAST_D;
      end
    end
  end

  // Read-data capture at beat end; rvalid and done trail the capture by one cycle.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      iRdata_r  <= 32'h0000_0000;
      dRdata_r  <= 32'h0000_0000;
      iRvalid_r <= 1'b0;
      dRvalid_r <= 1'b0;
      iDone_r   <= 1'b0;
      dDone_r   <= 1'b0;
    end else begin
      iRvalid_r <= (state_r == BUSY_I) && beatEnd_s;
      dRvalid_r <= (state_r == BUSY_DR) && beatEnd_s;
      iDone_r   <= (state_r == BUSY_I) && lineEnd_s;
      dDone_r   <= ((state_r == BUSY_DR) || (state_r == BUSY_DW)) && lineEnd_s;
      if ((state_r == BUSY_I) && beatEnd_s) begin
        iRdata_r <= mem_rdata;
      end
      if ((state_r == BUSY_DR) && beatEnd_s) begin
        dRdata_r <= mem_rdata;
      end
    end
  end

  // Memory-side and grant decode straight from the state register.
  always_comb begin
    iGrant_s   = 1'b0;
    dGrant_s   = 1'b0;
    memEn_s    = 1'b0;
    memWe_s    = 1'b0;
    memAddr_s  = 32'h0000_0000;
    memWdata_s = 32'h0000_0000;
    dWidx_s    = '0;
    case (state_r)
      BUSY_I: begin
        iGrant_s  = 1'b1;
        memEn_s   = 1'b1;
        memAddr_s = {lineAddr_r[31:WIDX_W+2], wordIdx_s, 2'b00};
      end
      BUSY_DR: begin
        dGrant_s  = 1'b1;
        memEn_s   = 1'b1;
        memAddr_s = {lineAddr_r[31:WIDX_W+2], wordIdx_s, 2'b00};
        dWidx_s   = wordIdx_s;
      end
      BUSY_DW: begin
        dGrant_s   = 1'b1;
        memEn_s    = 1'b1;
        memWe_s    = 1'b1;
        memAddr_s  = {lineAddr_r[31:WIDX_W+2], wordIdx_s, 2'b00};
        memWdata_s = d_wdata;
        dWidx_s    = wordIdx_s;
      end
      default: begin
        iGrant_s = 1'b0;
      end
    endcase
  end

  assign unusedLowBits_s = ^lineAddr_r[WIDX_W+1:0];

  assign i_grant   = iGrant_s;
  assign i_rdata   = iRdata_r;
  assign i_rvalid  = iRvalid_r;
  assign i_done    = iDone_r;
  assign d_grant   = dGrant_s;
  assign d_rdata   = dRdata_r;
  assign d_rvalid  = dRvalid_r;
  assign d_done    = dDone_r;
  assign d_widx    = dWidx_s;
  assign mem_en    = memEn_s;
  assign mem_we    = memWe_s;
  assign mem_addr  = memAddr_s;
  assign mem_wdata = memWdata_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle table for the basic I read plus
// hand sequences for ties, writes, back-to-back, reset abort and latency 1.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        iReq, dReq, dWe;
  logic [31:0] iAddr, dAddr, dWdata, memRdata;
  logic        iGrant, iRvalid, iDone, dGrant, dRvalid, dDone, memEn, memWe;
  logic [31:0] iRdata, dRdata, memAddr, memWdata;
  logic [1:0]  dWidx;

  logic        fReq, fDReq, fDWe;
  logic [31:0] fAddr, fDAddr, fDWdata, fMemRdata;
  logic        fGrant, fRvalid, fDone, fDGrant, fDRvalid, fDDone, fMemEn, fMemWe;
  logic [31:0] fRdata, fDRdata, fMemAddr, fMemWdata;
  logic [1:0]  fDWidx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Memory model: data is a fixed function of the word address.
  assign memRdata  = memAddr + 32'h5A00_0000;
  assign fMemRdata = fMemAddr + 32'h5A00_0000;
  always_comb dWdata = 32'h0000_00A0 + {30'd0, dWidx};

  mem_port_arbiter dut (
    .Clk(clk), .reset(reset),
    .i_req(iReq), .i_addr(iAddr), .i_grant(iGrant), .i_rdata(iRdata),
    .i_rvalid(iRvalid), .i_done(iDone),
    .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata), .d_widx(dWidx),
    .d_grant(dGrant), .d_rdata(dRdata), .d_rvalid(dRvalid), .d_done(dDone),
    .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata)
  );

  mem_port_arbiter #(.LINE_WORDS(4), .MEM_LATENCY(1)) dutFast (
    .Clk(clk), .reset(reset),
    .i_req(fReq), .i_addr(fAddr), .i_grant(fGrant), .i_rdata(fRdata),
    .i_rvalid(fRvalid), .i_done(fDone),
    .d_req(fDReq), .d_we(fDWe), .d_addr(fDAddr), .d_wdata(fDWdata), .d_widx(fDWidx),
    .d_grant(fDGrant), .d_rdata(fDRdata), .d_rvalid(fDRvalid), .d_done(fDDone),
    .mem_en(fMemEn), .mem_we(fMemWe), .mem_addr(fMemAddr), .mem_wdata(fMemWdata),
    .mem_rdata(fMemRdata)
  );

  typedef struct {
    logic        reqI;
    logic        gI, gD, en, we;
    logic [31:0] addr;
    logic        rv;
    logic [31:0] rdata;
    logic        iDn, dDn;
  } vec_t;

  typedef struct {
    int cyc;
    bit isD;
  } evt_t;

  vec_t        vecs[$];
  evt_t        gEv[$];
  evt_t        dnEv[$];
  int          iRvCnt, dRvCnt, firstIRv;
  logic [31:0] firstIRd, addrC1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic addRow(input logic reqI, gI, gD, en, we, input logic [31:0] addr,
                        input logic rv, input logic [31:0] rdata, input logic iDn, dDn);
    vec_t v;
    v.reqI = reqI; v.gI = gI; v.gD = gD; v.en = en; v.we = we; v.addr = addr;
    v.rv = rv; v.rdata = rdata; v.iDn = iDn; v.dDn = dDn;
    vecs.push_back(v);
  endtask

  // Reset both DUTs, then return at the start of cycle 0 with all requests low.
  task automatic doReset();
    reset = 1'b1;
    iReq = 1'b0; dReq = 1'b0; dWe = 1'b0; fReq = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Watch the main DUT for maxCyc cycles, logging grant rises and done pulses.
  task automatic run(input int maxCyc, input bit drop);
    bit prevIG, prevDG, sawID, sawDD;
    prevIG = 1'b0; prevDG = 1'b0;
    gEv.delete(); dnEv.delete();
    iRvCnt = 0; dRvCnt = 0; firstIRv = -1; firstIRd = '0; addrC1 = '0;
    for (int c = 0; c < maxCyc; c++) begin
      @(negedge clk);
      if (iGrant && !prevIG) gEv.push_back('{c, 1'b0});
      if (dGrant && !prevDG) gEv.push_back('{c, 1'b1});
      if (iDone) dnEv.push_back('{c, 1'b0});
      if (dDone) dnEv.push_back('{c, 1'b1});
      if (iRvalid) begin
        iRvCnt++;
        if (firstIRv < 0) begin
          firstIRv = c;
          firstIRd = iRdata;
        end
      end
      if (dRvalid) dRvCnt++;
      if (c == 1) addrC1 = memAddr;
      prevIG = iGrant; prevDG = dGrant;
      sawID = iDone; sawDD = dDone;
      @(posedge clk);
      #1;
      if (drop && sawID) iReq = 1'b0;
      if (drop && sawDD) dReq = 1'b0;
    end
  endtask

  function automatic logic [63:0] evtAt(input bit fromDone, input int idx);
    if (fromDone) begin
      if (idx < dnEv.size()) return {32'(dnEv[idx].cyc), 32'(dnEv[idx].isD)};
      else return 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      if (idx < gEv.size()) return {32'(gEv[idx].cyc), 32'(gEv[idx].isD)};
      else return 64'hFFFF_FFFF_FFFF_FFFF;
    end
  endfunction

  logic [31:0] fExpRd [8];
  int          w;

  initial begin
    iAddr = 32'h0; dAddr = 32'h0; fAddr = 32'h0; fDAddr = 32'h0;
    fDReq = 1'b0; fDWe = 1'b0; fDWdata = 32'h0;

    // Reset state: every output of both instances is zero.
    reset = 1'b1; iReq = 1'b0; dReq = 1'b0; dWe = 1'b0; fReq = 1'b0;
    @(negedge clk);
    check("reset_state",
          {iGrant, iRdata, iRvalid, iDone, dGrant, dRdata, dRvalid, dDone, dWidx,
           memEn, memWe, memAddr, memWdata},
          '0);
    check("reset_state_fast", {fGrant, fRdata, fRvalid, fDone, fMemEn, fMemAddr}, '0);

    // Test 1: I-only line read from 0x1010, cycle by cycle.
    addRow(1, 0, 0, 0, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0);
    for (int i = 1; i <= 3; i++) addRow(1, 1, 0, 1, 0, 32'h0000_1010, 0, 32'h0000_0000, 0, 0);
    addRow(1, 1, 0, 1, 0, 32'h0000_1014, 1, 32'h5A00_1010, 0, 0);
    for (int i = 5; i <= 6; i++) addRow(1, 1, 0, 1, 0, 32'h0000_1014, 0, 32'h5A00_1010, 0, 0);
    addRow(1, 1, 0, 1, 0, 32'h0000_1018, 1, 32'h5A00_1014, 0, 0);
    for (int i = 8; i <= 9; i++) addRow(1, 1, 0, 1, 0, 32'h0000_1018, 0, 32'h5A00_1014, 0, 0);
    addRow(1, 1, 0, 1, 0, 32'h0000_101C, 1, 32'h5A00_1018, 0, 0);
    for (int i = 11; i <= 12; i++) addRow(1, 1, 0, 1, 0, 32'h0000_101C, 0, 32'h5A00_1018, 0, 0);
    addRow(1, 0, 0, 0, 0, 32'h0000_0000, 1, 32'h5A00_101C, 1, 0);
    addRow(0, 0, 0, 0, 0, 32'h0000_0000, 0, 32'h5A00_101C, 0, 0);

    doReset();
    iAddr = 32'h0000_1010;
    for (int i = 0; i < vecs.size(); i++) begin
      iReq = vecs[i].reqI;
      @(negedge clk);
      check($sformatf("t1_cycle%0d", i),
            {iGrant, dGrant, memEn, memWe, memAddr, iRvalid, iRdata, iDone, dDone},
            {vecs[i].gI, vecs[i].gD, vecs[i].en, vecs[i].we, vecs[i].addr,
             vecs[i].rv, vecs[i].rdata, vecs[i].iDn, vecs[i].dDn});
      @(posedge clk);
      #1;
    end

    // Test 2: simultaneous requests after reset; D wins, I follows. Low D bits ignored.
    doReset();
    iAddr = 32'h0000_3000; dAddr = 32'h0000_400C; dWe = 1'b0;
    iReq = 1'b1; dReq = 1'b1;
    run(32, 1'b1);
    check("t2_grant0", evtAt(1'b0, 0), {32'd1, 32'd1});
    check("t2_done0",  evtAt(1'b1, 0), {32'd13, 32'd1});
    check("t2_grant1", evtAt(1'b0, 1), {32'd14, 32'd0});
    check("t2_done1",  evtAt(1'b1, 1), {32'd26, 32'd0});
    check("t2_rvalid_counts", {iRvCnt, dRvCnt}, {32'd4, 32'd4});
    check("t2_drdata_last", dRdata, 32'h5A00_400C);
    check("t2_irdata_last", iRdata, 32'h5A00_300C);

    // Test 3: D line write to 0x2000; write data follows d_widx live.
    doReset();
    dAddr = 32'h0000_2000; dWe = 1'b1; dReq = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      w = (c - 1) / 3;
      if (c >= 1 && c <= 12) begin
        check($sformatf("t3_cycle%0d", c),
              {dGrant, memEn, memWe, memAddr, memWdata, dWidx, dRvalid, dDone},
              {1'b1, 1'b1, 1'b1, 32'h0000_2000 + 32'(4 * w), 32'h0000_00A0 + 32'(w),
               2'(w), 1'b0, 1'b0});
      end else begin
        check($sformatf("t3_cycle%0d", c),
              {dGrant, memEn, memWe, memAddr, memWdata, dWidx, dRvalid, dDone},
              {1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, (c == 13)});
      end
      @(posedge clk);
      #1;
      if (c == 13) dReq = 1'b0;
    end

    // Test 4: both requests held for good; strict D, I, D, I alternation.
    doReset();
    iAddr = 32'h0000_5000; dAddr = 32'h0000_6000; dWe = 1'b0;
    iReq = 1'b1; dReq = 1'b1;
    run(55, 1'b0);
    check("t4_grant0", evtAt(1'b0, 0), {32'd1,  32'd1});
    check("t4_grant1", evtAt(1'b0, 1), {32'd14, 32'd0});
    check("t4_grant2", evtAt(1'b0, 2), {32'd27, 32'd1});
    check("t4_grant3", evtAt(1'b0, 3), {32'd40, 32'd0});
    check("t4_done3",  evtAt(1'b1, 3), {32'd52, 32'd0});
    iReq = 1'b0; dReq = 1'b0;

    // Test 5: reset at cycle 6 of an I read clears everything; retry restarts at word 0.
    doReset();
    iAddr = 32'h0000_1010; iReq = 1'b1;
    repeat (6) @(posedge clk);
    #1 reset = 1'b1; iReq = 1'b0;
    @(negedge clk);
    check("t5_reset_mid",
          {iGrant, iRdata, iRvalid, iDone, dGrant, dRdata, dRvalid, dDone, dWidx,
           memEn, memWe, memAddr, memWdata},
          '0);
    @(posedge clk);
    #1 reset = 1'b0; iReq = 1'b1;
    run(16, 1'b1);
    check("t5_regrant",  evtAt(1'b0, 0), {32'd1, 32'd0});
    check("t5_addr_c1",  addrC1, 32'h0000_1010);
    check("t5_first_rv", {32'(firstIRv), firstIRd}, {32'd4, 32'h5A00_1010});
    check("t5_done",     evtAt(1'b1, 0), {32'd13, 32'd0});

    // Test 6: latency-1 instance streams one word per cycle.
    fExpRd = '{32'h0, 32'h0, 32'h5A00_1010, 32'h5A00_1014,
               32'h5A00_1018, 32'h5A00_101C, 32'h5A00_101C, 32'h5A00_101C};
    doReset();
    fAddr = 32'h0000_1010; fReq = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("t6_cycle%0d", c), {fGrant, fRvalid, fDone, fRdata},
            {(c >= 1 && c <= 4), (c >= 2 && c <= 5), (c == 5), fExpRd[c]});
      @(posedge clk);
      #1;
      if (c == 5) fReq = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
